uart_cmd_decode: RTL and testbench

- Byte-stream command parser between uart_rx and the SDRAM controller's write-FIFO/arbiter interface.
- Consumes received bytes (rx_data plus the one-cycle po_flag strobe) and recognises write frames (header, then BURST_LEN payload bytes) and read frames (a single header byte).
- Pushes write payload into the SDRAM write FIFO.
- Raises level write/read requests that the SDRAM side acknowledges.

---
 rtl/uart_cmd_decode.sv | 141 ++++++++++++++
 tb/tb_uart_cmd_decode.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decode.sv
// Byte-stream command decoder: turns uart_rx bytes into SDRAM write-FIFO pushes
// and level write/read burst requests that stay up until acknowledged.
module uart_cmd_decode #(
  parameter int         BURST_LEN = 4,
  parameter logic [7:0] WR_HDR    = 8'h55,
  parameter logic [7:0] RD_HDR    = 8'hAA,
  parameter int         TIMEOUT   = 50000
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_flag,
  output logic       wfifo_wr_en,
  output logic [7:0] wfifo_data,
  output logic       wr_req,
  input  logic       wr_ack,
  output logic       rd_req,
  input  logic       rd_ack,
  output logic       frame_err,
  output logic       busy
);

  localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [7:0]      LAST_IDX = 8'(BURST_LEN - 1);
  // The abort fires on the cycle whose increment would bring the count to TIMEOUT-1.
  localparam logic [CW-1:0]   TERM_PRE = CW'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WR_DATA     = 2'd1,
    WAIT_WR_ACK = 2'd2,
    WAIT_RD_ACK = 2'd3
  } state_t;

  state_t          state_reg,       state_next;
  logic [7:0]      byte_cnt_reg,    byte_cnt_next;
  logic [CW-1:0]   idle_cnt_reg,    idle_cnt_next;
  logic            wfifo_wr_en_reg, wfifo_wr_en_next;
  logic [7:0]      wfifo_data_reg,  wfifo_data_next;
  logic            wr_req_reg,      wr_req_next;
  logic            rd_req_reg,      rd_req_next;
  logic            frame_err_reg,   frame_err_next;
  logic            timeout_hit;

  assign timeout_hit = (TIMEOUT < 2) || (idle_cnt_reg == TERM_PRE);

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_reg       <= IDLE;
      byte_cnt_reg    <= '0;
      idle_cnt_reg    <= '0;
      wfifo_wr_en_reg <= 1'b0;
      wfifo_data_reg  <= '0;
      wr_req_reg      <= 1'b0;
      rd_req_reg      <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      byte_cnt_reg    <= byte_cnt_next;
      idle_cnt_reg    <= idle_cnt_next;
      wfifo_wr_en_reg <= wfifo_wr_en_next;
      wfifo_data_reg  <= wfifo_data_next;
      wr_req_reg      <= wr_req_next;
      rd_req_reg      <= rd_req_next;
      frame_err_reg   <= frame_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    byte_cnt_next    = byte_cnt_reg;
    idle_cnt_next    = '0;
    wfifo_wr_en_next = 1'b0;
    wfifo_data_next  = wfifo_data_reg;
    wr_req_next      = 1'b0;
    rd_req_next      = 1'b0;
    frame_err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        byte_cnt_next = '0;
        if (rx_flag) begin
          if (rx_data == WR_HDR) begin
            state_next = WR_DATA;
          end else if (rx_data == RD_HDR) begin
            state_next  = WAIT_RD_ACK;
            rd_req_next = 1'b1;
          end
        end
      end

      WR_DATA: begin
        if (rx_flag) begin
          // Header values are plain payload here.
          wfifo_wr_en_next = 1'b1;
          wfifo_data_next  = rx_data;
          if (byte_cnt_reg == LAST_IDX) begin
            state_next    = WAIT_WR_ACK;
            byte_cnt_next = '0;
          end else begin
            byte_cnt_next = byte_cnt_reg + 8'd1;
          end
        end else if (timeout_hit) begin
          state_next     = IDLE;
          byte_cnt_next  = '0;
          frame_err_next = 1'b1;
        end else begin
          idle_cnt_next = idle_cnt_reg + CW'(1);
        end
      end

      WAIT_WR_ACK: begin
        wr_req_next    = 1'b1;
        frame_err_next = rx_flag;
        if (wr_req_reg && wr_ack) begin
          wr_req_next = 1'b0;
          state_next  = IDLE;
        end
      end

      WAIT_RD_ACK: begin
        rd_req_next    = 1'b1;
        frame_err_next = rx_flag;
        if (rd_req_reg && rd_ack) begin
          rd_req_next = 1'b0;
          state_next  = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign wfifo_wr_en = wfifo_wr_en_reg;
  assign wfifo_data  = wfifo_data_reg;
  assign wr_req      = wr_req_reg;
  assign rd_req      = rd_req_reg;
  assign frame_err   = frame_err_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_cmd_decode.sv
// Scoreboard bench for uart_cmd_decode: payload bytes are queued when sent and
// popped when the FIFO write strobe appears; handshakes are checked cycle-exactly.
module tb_uart_cmd_decode;

  localparam int BURST_LEN = 4;
  localparam int TIMEOUT   = 50;

  logic       sclk;
  logic       s_rst;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic       wfifo_wr_en;
  logic [7:0] wfifo_data;
  logic       wr_req;
  logic       wr_ack;
  logic       rd_req;
  logic       rd_ack;
  logic       frame_err;
  logic       busy;

  uart_cmd_decode #(
    .BURST_LEN(BURST_LEN),
    .WR_HDR   (8'h55),
    .RD_HDR   (8'hAA),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .sclk       (sclk),
    .s_rst      (s_rst),
    .rx_data    (rx_data),
    .rx_flag    (rx_flag),
    .wfifo_wr_en(wfifo_wr_en),
    .wfifo_data (wfifo_data),
    .wr_req     (wr_req),
    .wr_ack     (wr_ack),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int         check_cnt = 0;
  int         err_cnt   = 0;
  int         err_pulses = 0;
  int         err_base;
  logic [7:0] exp_q[$];
  logic       flag_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor on the falling edge, away from the sampling edge.
  always @(negedge sclk) begin
    if (wfifo_wr_en) begin
      check("wr_latency", 32'(flag_prev), 32'd1);
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [7:0] exp_b;
        exp_b = exp_q.pop_front();
        check("wr_data", 32'(wfifo_data), 32'(exp_b));
        $display("fifo write %02h (expected %02h)", wfifo_data, exp_b);
      end
    end
    if (frame_err) err_pulses++;
    check("req_mutex", 32'(wr_req & rd_req), 32'd0);
    flag_prev = rx_flag;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  // Strobe lands gap+2 cycles after the previous one; payload bytes go to the scoreboard.
  task automatic send_byte(input logic [7:0] b, input bit payload, input int gap);
    if (gap > 0) tick(gap);
    tick(1);
    rx_data = b;
    rx_flag = 1'b1;
    if (payload) exp_q.push_back(b);
    tick(1);
    rx_flag = 1'b0;
  endtask

  task automatic write_frame(input logic [31:0] bytes, input int gap, input bit do_ack);
    send_byte(8'h55, 1'b0, gap);
    for (int i = 3; i >= 0; i--) send_byte(bytes[i*8 +: 8], 1'b1, gap);
    check("wr_req_early", 32'(wr_req), 32'd0);
    tick(1);
    check("wr_req_rise", 32'(wr_req), 32'd1);
    check("busy_wait_wr", 32'(busy), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("write frame %08h complete, wr_req raised", bytes);
    if (do_ack) begin
      wr_ack = 1'b1;
      tick(1);
      wr_ack = 1'b0;
      check("wr_req_drop", 32'(wr_req), 32'd0);
      check("busy_after_wr", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    s_rst   = 1'b1;
    rx_data = 8'h00;
    rx_flag = 1'b0;
    wr_ack  = 1'b0;
    rd_ack  = 1'b0;
    tick(3);
    s_rst = 1'b0;
    check("rst_wr_en", 32'(wfifo_wr_en), 32'd0);
    check("rst_data", 32'(wfifo_data), 32'd0);
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick(2);

    // Basic write frame with 20-cycle gaps.
    write_frame(32'h11223344, 20, 1'b1);

    // Noise bytes, then a read frame.
    err_base = err_pulses;
    send_byte(8'h00, 1'b0, 3);
    send_byte(8'h7F, 1'b0, 3);
    tick(1);
    check("noise_busy", 32'(busy), 32'd0);
    check("noise_err", 32'(err_pulses - err_base), 32'd0);
    send_byte(8'hAA, 1'b0, 3);
    check("rd_req_rise", 32'(rd_req), 32'd1);
    check("rd_busy", 32'(busy), 32'd1);
    tick(98);
    check("rd_req_hold", 32'(rd_req), 32'd1);
    wr_ack = 1'b1;
    tick(1);
    wr_ack = 1'b0;
    check("rd_other_ack", 32'(rd_req), 32'd1);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    check("rd_req_drop", 32'(rd_req), 32'd0);
    check("rd_busy_drop", 32'(busy), 32'd0);
    $display("read frame complete");

    // Timeout after a partial frame.
    err_base = err_pulses;
    send_byte(8'h55, 1'b0, 3);
    send_byte(8'h11, 1'b1, 2);
    tick(48);
    check("to_not_yet", 32'(frame_err), 32'd0);
    check("to_busy_pre", 32'(busy), 32'd1);
    tick(1);
    check("to_err", 32'(frame_err), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
    tick(1);
    check("to_err_pulse", 32'(frame_err), 32'd0);
    check("to_err_count", 32'(err_pulses - err_base), 32'd1);
    $display("timeout abort observed");
    write_frame(32'hA1A2A3A4, 3, 1'b1);

    // Byte on the timeout terminal cycle wins; header values travel as payload.
    err_base = err_pulses;
    send_byte(8'h55, 1'b0, 3);
    send_byte(8'h11, 1'b1, 47);
    check("term_no_abort", 32'(frame_err), 32'd0);
    check("term_busy", 32'(busy), 32'd1);
    send_byte(8'h55, 1'b1, 5);
    send_byte(8'hAA, 1'b1, 5);
    send_byte(8'h22, 1'b1, 5);
    check("hdr_payload_rd", 32'(rd_req), 32'd0);
    tick(1);
    check("hdr_payload_wr", 32'(wr_req), 32'd1);
    wr_ack = 1'b1;
    tick(1);
    wr_ack = 1'b0;
    check("term_wr_drop", 32'(wr_req), 32'd0);
    check("term_err_count", 32'(err_pulses - err_base), 32'd0);
    $display("terminal-cycle frame complete");

    // Bytes arriving while waiting for an ack are dropped with frame_err.
    write_frame(32'hC1C2C3C4, 2, 1'b0);
    send_byte(8'hAA, 1'b0, 2);
    check("drop_err", 32'(frame_err), 32'd1);
    check("drop_no_rd", 32'(rd_req), 32'd0);
    check("drop_wr_hold", 32'(wr_req), 32'd1);
    tick(1);
    check("drop_err_pulse", 32'(frame_err), 32'd0);
    wr_ack  = 1'b1;
    rx_data = 8'h55;
    rx_flag = 1'b1;
    tick(1);
    wr_ack  = 1'b0;
    rx_flag = 1'b0;
    check("ackflag_wr_drop", 32'(wr_req), 32'd0);
    check("ackflag_err", 32'(frame_err), 32'd1);
    check("ackflag_idle", 32'(busy), 32'd0);
    tick(1);
    check("ackflag_no_hdr", 32'(busy), 32'd0);
    check("ackflag_err_end", 32'(frame_err), 32'd0);
    $display("busy-drop cases complete");

    // Reset in the middle of a frame.
    send_byte(8'h55, 1'b0, 3);
    send_byte(8'h11, 1'b1, 2);
    tick(1);
    s_rst = 1'b1;
    tick(1);
    s_rst = 1'b0;
    check("mrst_wr_en", 32'(wfifo_wr_en), 32'd0);
    check("mrst_wr_req", 32'(wr_req), 32'd0);
    check("mrst_rd_req", 32'(rd_req), 32'd0);
    check("mrst_err", 32'(frame_err), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    wr_ack = 1'b1;
    tick(1);
    wr_ack = 1'b0;
    check("spur_ack_req", 32'(wr_req), 32'd0);
    check("spur_ack_busy", 32'(busy), 32'd0);
    write_frame(32'hD1D2D3D4, 4, 1'b1);

    tick(5);
    check("sb_final", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
